// File: rtl/processorci_bus_arbiter.sv
// N-master to single-slave memory bus arbiter: round-robin grant, per-master
// ack/err pulses and a response watchdog that forces completion of stalled reads/writes.
module processorci_bus_arbiter #(
  parameter int                    NUM_MASTERS    = 2,
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    TIMEOUT_CYCLES = 255,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA       = '0,
  localparam int                   IDX_W          = $clog2((NUM_MASTERS > 2) ? NUM_MASTERS : 2)
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [NUM_MASTERS-1:0]            m_req,
  input  logic [NUM_MASTERS-1:0]            m_we,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata,
  output logic [DATA_WIDTH-1:0]             m_rdata,
  output logic [NUM_MASTERS-1:0]            m_ack,
  output logic [NUM_MASTERS-1:0]            m_err,
  output logic                              s_read,
  output logic                              s_write,
  output logic [ADDR_WIDTH-1:0]             s_addr,
  output logic [DATA_WIDTH-1:0]             s_wdata,
  input  logic [DATA_WIDTH-1:0]             s_rdata,
  input  logic                              s_response,
  output logic [IDX_W-1:0]                  grant_idx,
  output logic [7:0]                        timeout_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // The watchdog only has to reach TIMEOUT_CYCLES-1, so clog2(TIMEOUT_CYCLES) bits suffice.
  localparam int              WD_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit              WD_EN   = (TIMEOUT_CYCLES > 0);
  localparam logic [WD_W-1:0] WD_LAST = WD_EN ? WD_W'(TIMEOUT_CYCLES - 1) : '0;

  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_MASTERS];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_MASTERS];

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_unpack
    assign addr_arr[i]  = m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[i] = m_wdata[i*DATA_WIDTH +: DATA_WIDTH];
  end

  state_e                 state_q,   state_d;
  logic [IDX_W-1:0]       ptr_q,     ptr_d;
  logic [IDX_W-1:0]       grant_q,   grant_d;
  logic                   s_read_q,  s_read_d;
  logic                   s_write_q, s_write_d;
  logic [ADDR_WIDTH-1:0]  s_addr_q,  s_addr_d;
  logic [DATA_WIDTH-1:0]  s_wdata_q, s_wdata_d;
  logic [DATA_WIDTH-1:0]  rdata_q,   rdata_d;
  logic [NUM_MASTERS-1:0] ack_q,     ack_d;
  logic [NUM_MASTERS-1:0] err_q,     err_d;
  logic [WD_W-1:0]        wd_q,      wd_d;
  logic [7:0]             tcount_q,  tcount_d;

  logic                   win_found;
  logic [IDX_W-1:0]       win_idx;
  logic [NUM_MASTERS-1:0] grant_oh;

  // (base + offset) mod NUM_MASTERS without a general divider; offset < NUM_MASTERS.
  function automatic logic [IDX_W-1:0] rr_index(input logic [IDX_W-1:0] base, input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= NUM_MASTERS) sum = sum - NUM_MASTERS;
    return IDX_W'(sum);
  endfunction

  // Round-robin search: first requester at or after ptr, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (!win_found && m_req[rr_index(ptr_q, k)]) begin
        win_found = 1'b1;
        win_idx   = rr_index(ptr_q, k);
      end
    end
  end

  assign grant_oh = NUM_MASTERS'(1) << grant_q;

  always_comb begin
    // NOTE: every _d starts from its _q (or from zero for pulses) so no path leaves a
    // variable unassigned; a missing default here would infer a latch.
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    s_read_d  = s_read_q;
    s_write_d = s_write_q;
    s_addr_d  = s_addr_q;
    s_wdata_d = s_wdata_q;
    rdata_d   = rdata_q;
    ack_d     = '0;
    err_d     = '0;
    wd_d      = wd_q;
    tcount_d  = tcount_q;

    unique case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d   = ST_BUSY;
          grant_d   = win_idx;
          ptr_d     = rr_index(win_idx, 1);
          s_read_d  = ~m_we[win_idx];
          s_write_d = m_we[win_idx];
          s_addr_d  = addr_arr[win_idx];
          s_wdata_d = wdata_arr[win_idx];
          wd_d      = '0;
        end
      end

      ST_BUSY: begin
        // A response in the expiry cycle takes priority over the watchdog.
        if (s_response) begin
          state_d   = ST_DONE;
          s_read_d  = 1'b0;
          s_write_d = 1'b0;
          rdata_d   = s_rdata;
          ack_d     = grant_oh;
        end else if (WD_EN && (wd_q == WD_LAST)) begin
          state_d   = ST_DONE;
          s_read_d  = 1'b0;
          s_write_d = 1'b0;
          rdata_d   = ERR_DATA;
          ack_d     = grant_oh;
          err_d     = grant_oh;
          if (tcount_q != 8'hFF) tcount_d = tcount_q + 8'd1;
        end else if (WD_EN) begin
          wd_d = wd_q + 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d   = ST_IDLE;
        s_read_d  = 1'b0;
        s_write_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      grant_q   <= '0;
      s_read_q  <= 1'b0;
      s_write_q <= 1'b0;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
      rdata_q   <= '0;
      ack_q     <= '0;
      err_q     <= '0;
      wd_q      <= '0;
      tcount_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      s_read_q  <= s_read_d;
      s_write_q <= s_write_d;
      s_addr_q  <= s_addr_d;
      s_wdata_q <= s_wdata_d;
      rdata_q   <= rdata_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      wd_q      <= wd_d;
      tcount_q  <= tcount_d;
    end
  end

  assign m_rdata       = rdata_q;
  assign m_ack         = ack_q;
  assign m_err         = err_q;
  assign s_read        = s_read_q;
  assign s_write       = s_write_q;
  assign s_addr        = s_addr_q;
  assign s_wdata       = s_wdata_q;
  assign grant_idx     = grant_q;
  assign timeout_count = tcount_q;

endmodule

// File: doc/processorci_bus_arbiter.md
# processorci_bus_arbiter

Parametrised N-master to single-slave memory bus arbiter. It sits between one or more core bus ports (instruction, data, or several cores) and the Controller's main-memory bus (read/write strobes, address, write data, read data, response). It provides round-robin arbitration, a request/acknowledge handshake per master, and a response-timeout watchdog that keeps a stalled memory from hanging a core.

## Interface
- NUM_MASTERS, 2, number of master ports (1..8)
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width
- TIMEOUT_CYCLES, 255, cycles in BUSY before forced error completion; 0 disables the watchdog
- ERR_DATA, 0, value returned on m_rdata for a timed-out transaction
- One clock; reset is asynchronous and active-low.
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- m_req  in  NUM_MASTERS  per-master request level
- m_we  in  NUM_MASTERS  per-master write enable (1 = write)
- m_addr  in  NUM_MASTERS*ADDR_WIDTH  packed addresses; master i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- m_wdata  in  NUM_MASTERS*DATA_WIDTH  packed write data
- m_rdata  out  DATA_WIDTH  shared read data, registered
- m_ack  out  NUM_MASTERS  one-cycle completion pulse per master
- m_err  out  NUM_MASTERS  one-cycle timeout flag, coincident with m_ack
- s_read  out  1  slave read strobe
- s_write  out  1  slave write strobe
- s_addr  out  ADDR_WIDTH  slave address
- s_wdata  out  DATA_WIDTH  slave write data
- s_rdata  in  DATA_WIDTH  slave read data, valid with s_response
- s_response  in  1  slave completion
- grant_idx  out  clog2(max(NUM_MASTERS,2))  index of the current or last granted master
- timeout_count  out  8  saturating count of timeouts

## Operation
- FSM states:
  - IDLE: if any m_req is high, latch winner g, its we/addr/wdata, go BUSY; else stay.
  - BUSY: s_read = ~we_l, s_write = we_l, s_addr/s_wdata from latched values. On s_response: latch s_rdata (writes: latch anyway), go DONE. On watchdog expiry: rdata = ERR_DATA, set err, go DONE.
  - DONE: m_ack[g] = 1, m_err[g] = err, m_rdata stable; go IDLE.
- Round-robin: search starts at ptr, wraps modulo NUM_MASTERS. On grant, ptr = (g+1) mod NUM_MASTERS. Reset ptr = 0.
- Master rules:
  - Hold req/we/addr/wdata stable until ack.
  - May drop req the cycle after ack, or keep it high with new fields for a back-to-back request. A master that drops req before ack has its request ignored; the arbiter does not abort an issued transaction.
- s_response outside BUSY is ignored.
- The watchdog counter clears on entry to BUSY. Expiry occurs when counter == TIMEOUT_CYCLES-1 with no s_response. An s_response arriving in the expiry cycle wins and is not counted as a timeout.
- timeout_count saturates at 255.
- NUM_MASTERS = 1: ptr is constant 0; grant_idx is always 0.

## Timing
- Reset values: all outputs 0 (m_rdata, m_ack, m_err, s_read, s_write, s_addr, s_wdata, grant_idx, timeout_count); state IDLE; ptr 0. Reset mid-transaction drops strobes immediately, with no ack.
- req high in cycle 0 (IDLE) -> s_read/s_write high cycles 1..k, where k is the first cycle with s_response -> m_ack cycle k+1 -> IDLE cycle k+2.
- Minimum 3 cycles per transaction. Maximum BUSY residency is TIMEOUT_CYCLES cycles.
- Strobes, address and write data are registered and glitch-free; they are constant throughout BUSY.
- grant_idx updates on the IDLE->BUSY edge and holds through DONE and IDLE.

## Test plan
- Single read: master 0 reads 0x100, slave responds 2 cycles after strobe with 0xCAFEBABE -> s_read high 2 cycles, m_ack[0] pulses once, m_rdata = 0xCAFEBABE, m_err = 0.
- Simultaneous: after reset masters 0 and 1 request together, both held -> grant order 0,1,0,1; each m_ack one cycle; no starvation over 20 transactions.
- Write: master 1 writes 0x12345678 to 0x2000 -> s_write = 1, s_read = 0, s_addr = 0x2000, s_wdata = 0x12345678 for the entire BUSY phase; m_ack[1] pulses.
- Timeout: TIMEOUT_CYCLES = 8, slave silent -> BUSY exactly 8 cycles, m_ack[g] and m_err[g] high together, m_rdata = ERR_DATA, timeout_count = 1. Response in the 8th cycle -> m_err = 0, count unchanged.
- Reset mid-op: reset_n low during BUSY -> s_read low asynchronously, no ack. After release, master 0 wins first.
- NUM_MASTERS = 4, only master 3 requesting continuously -> back-to-back grants to 3 every 3 cycles (1-cycle slave), grant_idx = 3.
